cp0_unit: RTL and testbench

- Coprocessor-0 exception/interrupt controller for the 5-stage MIPS core. Sits at the M stage.
- Collects the exception code, branch-delay flag and PC of the instruction in M, plus the six hardware interrupt lines.
- Produces the flush/redirect request consumed by next-PC selection (redirect to 0x00004180) and the EPC target used on eret.
- Holds SR, Cause, EPC and PRId. Serves mfc0/mtc0.

---
 rtl/cp0_unit_pkg.sv | 25 ++
 rtl/cp0_unit.sv | 102 ++++++++++
 tb/tb_cp0_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cp0_unit_pkg.sv
// CP0 shared definitions: register numbers, exception codes, field positions.
package cp0_unit_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

    localparam int SR_IE_BIT    = 0;
    localparam int SR_EXL_BIT   = 1;
    localparam int IM_LO        = 10;
    localparam int IM_HI        = 15;
    localparam int CAUSE_BD_BIT = 31;
    localparam int EXC_LO       = 2;
    localparam int EXC_HI       = 6;

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor-0: SR/Cause/EPC/PRId, exception and interrupt request
// generation for the M stage.
module cp0_unit
    import cp0_unit_pkg::*;
#(
    parameter logic [31:0] PRID  = 32'h0000_0721,
    parameter int          IRQ_W = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic [4:0]  exc_m,
    input  logic [5:0]  hwint,
    input  logic [4:0]  cp0_addr,
    input  logic        cp0_we,
    input  logic [31:0] cp0_wdata,
    input  logic        eret_m,
    output logic [31:0] cp0_rdata,
    output logic [31:0] epc,
    output logic        req
);

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc_q;

    logic        int_req;
    logic        exc_req;
    logic [31:0] pc_al;
    logic [31:0] epc_new;

    assign int_req = (|(hwint & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req = (exc_m != 5'd0) & ~sr_exl;
    assign req     = int_req | exc_req;

    // A delay-slot instruction restarts at its branch.
    assign pc_al   = {pc_m[31:2], 2'b00};
    assign epc_new = bd_m ? pc_al - 32'd4 : pc_al;

    assign epc = (cp0_we && cp0_addr == CP0_EPC)
                 ? {cp0_wdata[31:2], 2'b00} : epc_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc_q     <= '0;
        end else begin
            cause_ip <= hwint;
            if (req) begin
                sr_exl    <= 1'b1;
                cause_exc <= int_req ? EXC_INT : exc_m;
                cause_bd  <= bd_m;
                epc_q     <= epc_new;
            end else begin
                if (cp0_we) begin
                    unique case (cp0_addr)
                        CP0_SR: begin
                            sr_im  <= cp0_wdata[IM_HI:IM_LO];
                            sr_exl <= cp0_wdata[SR_EXL_BIT];
                            sr_ie  <= cp0_wdata[SR_IE_BIT];
                        end
                        CP0_EPC: epc_q <= {cp0_wdata[31:2], 2'b00};
                        default: ;
                    endcase
                end
                // Placed after the SR write so eret wins on EXL.
                if (eret_m)
                    sr_exl <= 1'b0;
            end
        end
    end

    always_comb begin
        cp0_rdata = '0;
        unique case (cp0_addr)
            CP0_SR: begin
                cp0_rdata[IM_HI:IM_LO]  = sr_im;
                cp0_rdata[SR_EXL_BIT]   = sr_exl;
                cp0_rdata[SR_IE_BIT]    = sr_ie;
            end
            CP0_CAUSE: begin
                cp0_rdata[CAUSE_BD_BIT]  = cause_bd;
                cp0_rdata[IM_HI:IM_LO]   = cause_ip;
                cp0_rdata[EXC_HI:EXC_LO] = cause_exc;
            end
            CP0_EPC:  cp0_rdata = epc_q;
            CP0_PRID: cp0_rdata = PRID;
            default:  cp0_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed checks of cp0_unit: reset, interrupts, exceptions,
// suppression, eret, EPC forwarding and reset priority.
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [4:0]  exc_m;
    logic [5:0]  hwint;
    logic [4:0]  cp0_addr;
    logic        cp0_we;
    logic [31:0] cp0_wdata;
    logic        eret_m;
    logic [31:0] cp0_rdata;
    logic [31:0] epc;
    logic        req;

    int vectors = 0;
    int miscompares = 0;

    cp0_unit dut (
        .clk(clk), .reset(reset), .pc_m(pc_m), .bd_m(bd_m),
        .exc_m(exc_m), .hwint(hwint), .cp0_addr(cp0_addr),
        .cp0_we(cp0_we), .cp0_wdata(cp0_wdata), .eret_m(eret_m),
        .cp0_rdata(cp0_rdata), .epc(epc), .req(req)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [4:0] a,
                      input logic [31:0] exp);
        cp0_addr = a;
        #1;
        chk(tag, cp0_rdata, exp);
    endtask

    initial begin
        reset = 1'b0; pc_m = '0; bd_m = 1'b0; exc_m = '0;
        hwint = 6'h3F; cp0_addr = '0; cp0_we = 1'b0;
        cp0_wdata = '0; eret_m = 1'b0;

        step(); step();
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_epc", epc, 32'd0);

        reset = 1'b1;
        step();
        rd("rst_sr", 5'd12, 32'h0);
        rd("rst_cause", 5'd13, 32'h0000_FC00);
        rd("rst_epcreg", 5'd14, 32'h0);
        rd("prid", 5'd15, 32'h0000_0721);
        rd("unmapped", 5'd3, 32'h0);

        // Enable IM[0] and IE.
        hwint = 6'h00;
        cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
        step();
        cp0_we = 1'b0;
        rd("sr_wr", 5'd12, 32'h0000_0401);

        // Interrupt.
        hwint = 6'h01; pc_m = 32'h0000_3010;
        #1;
        chk("int_req", {31'd0, req}, 32'd1);
        step();
        rd("int_cause", 5'd13, 32'h0000_0400);
        rd("int_epc", 5'd14, 32'h0000_3010);
        rd("int_sr", 5'd12, 32'h0000_0403);
        chk("int_req_off", {31'd0, req}, 32'd0);

        // Nested exception suppressed.
        exc_m = 5'd4;
        #1;
        chk("nest_req", {31'd0, req}, 32'd0);
        step();
        exc_m = 5'd0;
        rd("nest_cause", 5'd13, 32'h0000_0400);
        rd("nest_epc", 5'd14, 32'h0000_3010);

        // eret re-enables; pending interrupt raises req.
        eret_m = 1'b1;
        step();
        eret_m = 1'b0;
        rd("eret_sr", 5'd12, 32'h0000_0401);
        chk("eret_pend", {31'd0, req}, 32'd1);
        hwint = 6'h00;
        #1;
        chk("pend_gone", {31'd0, req}, 32'd0);

        // Delay-slot overflow.
        exc_m = 5'd12; bd_m = 1'b1; pc_m = 32'h0000_3024;
        #1;
        chk("bd_req", {31'd0, req}, 32'd1);
        step();
        exc_m = 5'd0; bd_m = 1'b0;
        rd("bd_epc", 5'd14, 32'h0000_3020);
        rd("bd_cause", 5'd13, 32'h8000_0030);
        eret_m = 1'b1;
        step();
        eret_m = 1'b0;

        // Interrupt beats RI.
        exc_m = 5'd10; hwint = 6'h01; pc_m = 32'h0000_3040;
        #1;
        chk("prio_req", {31'd0, req}, 32'd1);
        step();
        exc_m = 5'd0;
        rd("prio_cause", 5'd13, 32'h0000_0400);
        rd("prio_epc", 5'd14, 32'h0000_3040);

        // mtc0 EPC with eret: forwarded target.
        cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_3103;
        eret_m = 1'b1;
        #1;
        chk("fwd_req", {31'd0, req}, 32'd0);
        chk("fwd_epc", epc, 32'h0000_3100);
        step();
        cp0_we = 1'b0; eret_m = 1'b0; hwint = 6'h00;
        rd("fwd_epcreg", 5'd14, 32'h0000_3100);
        rd("fwd_sr", 5'd12, 32'h0000_0401);

        // Masked line: IP tracks, no req.
        hwint = 6'h02;
        #1;
        chk("mask_req", {31'd0, req}, 32'd0);
        step();
        rd("mask_ip", 5'd13, 32'h0000_0800);
        hwint = 6'h00;

        // EPC wrap for delay slot at pc 0.
        exc_m = 5'd5; bd_m = 1'b1; pc_m = 32'h0;
        step();
        exc_m = 5'd0; bd_m = 1'b0;
        rd("wrap_epc", 5'd14, 32'hFFFF_FFFC);
        rd("wrap_cause", 5'd13, 32'h8000_0014);
        eret_m = 1'b1;
        step();
        eret_m = 1'b0;

        // Reset beats an exception.
        exc_m = 5'd4; pc_m = 32'h0000_5000; reset = 1'b0;
        #1;
        chk("rp_req_pre", {31'd0, req}, 32'd1);
        step();
        reset = 1'b1; exc_m = 5'd0;
        rd("rp_sr", 5'd12, 32'h0);
        rd("rp_cause", 5'd13, 32'h0);
        rd("rp_epcreg", 5'd14, 32'h0);
        chk("rp_epc", epc, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
